pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 164 ++++++++++++++++
 tb/tb_pipe_addsub.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_addsub                                                                |
// | Segmented carry-lookahead adder/subtractor with skewed operands, optional  |
// | signed saturation and a globally stalled valid/ready pipeline.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         sat,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  localparam int           c_seg_w   = N / STAGES;
  localparam logic [N-1:0] c_sat_max = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] c_sat_min = {1'b1, {(N-1){1'b0}}};

  if ((N % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_addsub: N must be a multiple of STAGES");
  end

  // One global advance: every stage moves together or holds together.
  assign in_ready = out_ready || !out_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [c_seg_w-1:0]         w_xs;
    logic [c_seg_w-1:0]         w_ys;
    logic [c_seg_w-1:0]         w_ym;
    logic [c_seg_w-1:0]         w_g;
    logic [c_seg_w-1:0]         w_p;
    logic [c_seg_w-1:0]         w_s;
    logic [c_seg_w:0]           w_c;
    logic [(k+1)*c_seg_w-1:0]   w_acc;
    logic                       w_vin;
    logic                       w_sub;
    logic                       w_sat;
    logic                       w_cin;
    logic                       w_pp;
    logic                       w_t;
    logic                       r_vld;
    logic                       r_c;

    if (k == 0) begin : g_head
      assign w_xs  = x[c_seg_w-1:0];
      assign w_ys  = y[c_seg_w-1:0];
      assign w_vin = in_valid;
      assign w_sub = sub;
      assign w_sat = sat;
      assign w_cin = sub;
      assign w_acc = w_s;
    end else begin : g_body
      assign w_xs  = g_stage[k-1].g_fwd.r_xu[c_seg_w-1:0];
      assign w_ys  = g_stage[k-1].g_fwd.r_yu[c_seg_w-1:0];
      assign w_vin = g_stage[k-1].r_vld;
      assign w_sub = g_stage[k-1].g_fwd.r_sub;
      assign w_sat = g_stage[k-1].g_fwd.r_sat;
      assign w_cin = g_stage[k-1].r_c;
      assign w_acc = {w_s, g_stage[k-1].g_fwd.r_res};
    end

    // Flattened lookahead: each carry is a sum of generate/propagate products.
    always_comb begin
      w_ym   = w_ys ^ {c_seg_w{w_sub}};
      w_g    = w_xs & w_ym;
      w_p    = w_xs ^ w_ym;
      w_c    = '0;
      w_pp   = 1'b0;
      w_t    = 1'b0;
      w_c[0] = w_cin;
      for (int i = 0; i < c_seg_w; i++) begin
        w_t  = w_g[i];
        w_pp = w_p[i];
        for (int j = i - 1; j >= 0; j--) begin
          w_t  = w_t | (w_pp & w_g[j]);
          w_pp = w_pp & w_p[j];
        end
        w_c[i+1] = w_t | (w_pp & w_cin);
      end
      w_s = w_p ^ w_c[c_seg_w-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
      end else if (in_ready) begin
        r_vld <= w_vin;
        r_c   <= w_c[c_seg_w];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int c_up_w = N - (k + 1) * c_seg_w;
      logic [c_up_w-1:0]        r_xu;
      logic [c_up_w-1:0]        r_yu;
      logic [c_up_w-1:0]        w_xn;
      logic [c_up_w-1:0]        w_yn;
      logic [(k+1)*c_seg_w-1:0] r_res;
      logic                     r_sub;
      logic                     r_sat;

      if (k == 0) begin : g_up_head
        assign w_xn = x[N-1:c_seg_w];
        assign w_yn = y[N-1:c_seg_w];
      end else begin : g_up_body
        assign w_xn = g_stage[k-1].g_fwd.r_xu[N-k*c_seg_w-1:c_seg_w];
        assign w_yn = g_stage[k-1].g_fwd.r_yu[N-k*c_seg_w-1:c_seg_w];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_xu  <= '0;
          r_yu  <= '0;
          r_res <= '0;
          r_sub <= 1'b0;
          r_sat <= 1'b0;
        end else if (in_ready) begin
          r_xu  <= w_xn;
          r_yu  <= w_yn;
          r_res <= w_acc;
          r_sub <= w_sub;
          r_sat <= w_sat;
        end
      end
    end else begin : g_last
      logic         w_ovf;
      logic [N-1:0] r_sum;
      logic         r_ovf;

      // Overflow is reported unsaturated; clamp direction follows x's sign.
      assign w_ovf = w_c[c_seg_w] ^ w_c[c_seg_w-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum <= '0;
          r_ovf <= 1'b0;
        end else if (in_ready) begin
          r_sum <= (w_sat && w_ovf) ? (w_xs[c_seg_w-1] ? c_sat_min : c_sat_max) : w_acc;
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign carry     = g_stage[STAGES-1].r_c;
  assign sum       = g_stage[STAGES-1].g_last.r_sum;
  assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_addsub                                                             |
// | Directed 8-bit/2-stage scenarios plus a randomized 32-bit/4-stage stream.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_sub, a_sat, a_out_valid, a_out_ready, a_carry, a_ovf;
  logic [7:0] a_x, a_y, a_sum;

  logic        b_in_valid, b_in_ready, b_sub, b_sat, b_out_valid, b_out_ready, b_carry, b_ovf;
  logic [31:0] b_x, b_y, b_sum;

  pipe_addsub #(.N(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sub(a_sub), .sat(a_sat), .x(a_x), .y(a_y), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sum(a_sum), .carry(a_carry), .overflow(a_ovf)
  );

  pipe_addsub #(.N(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sub(b_sub), .sat(b_sat), .x(b_x), .y(b_y), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sum(b_sum), .carry(b_carry), .overflow(b_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          cyc;
    int          stl;
  } exp_t;

  // Reference: exact integer arithmetic, then wrap or clamp.
  function automatic exp_t model32(logic [31:0] x, logic [31:0] y, logic sub, logic sat);
    exp_t   e;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    longint r  = sub ? (sx - sy) : (sx + sy);
    e.o   = (r > 64'sd2147483647) || (r < -(64'sd2147483648));
    e.c   = sub ? (ux >= uy) : ((ux + uy) > 64'sd4294967295);
    e.s   = r[31:0];
    if (sat && e.o) e.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    e.cyc = 0;
    e.stl = 0;
    return e;
  endfunction

  task automatic drive8(input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic st);
    a_in_valid = v; a_x = x; a_y = y; a_sub = s; a_sat = st;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_sub = 1'b0; b_sat = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready8: got %b want 1", a_in_ready); else n_pass++;
    n_chk++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid8: got %b want 0", a_out_valid); else n_pass++;
    n_chk++; if (a_sum !== 8'h00) $display("FAIL reset_sum8: got %h want 00", a_sum); else n_pass++;
    n_chk++; if (a_carry !== 1'b0 || a_ovf !== 1'b0)
      $display("FAIL reset_flags8: got c=%b o=%b want 0 0", a_carry, a_ovf); else n_pass++;
    n_chk++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_sum !== 32'h0)
      $display("FAIL reset_dut32: got rdy=%b vld=%b sum=%h want 1 0 0", b_in_ready, b_out_valid, b_sum); else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_chk++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
      $display("FAIL post_reset8: got rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid); else n_pass++;
  endtask

  task automatic test_directed;
    logic [7:0] dx[4] = '{8'h7F, 8'h7F, 8'h10, 8'h80};
    logic [7:0] dy[4] = '{8'h01, 8'h01, 8'h20, 8'h01};
    logic       ds[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       dt[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] es[4] = '{8'h80, 8'h7F, 8'hF0, 8'h80};
    logic       ec[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       eo[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive8(1'b1, dx[i], dy[i], ds[i], dt[i]);
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      n_chk++; if (a_out_valid !== 1'b0) $display("FAIL dir%0d_early: got vld=%b want 0", i, a_out_valid); else n_pass++;
      @(negedge clk);
      #1;
      n_chk++;
      if (a_out_valid !== 1'b1 || a_sum !== es[i] || a_carry !== ec[i] || a_ovf !== eo[i])
        $display("FAIL dir%0d: got vld=%b sum=%h c=%b o=%b want 1 %h %b %b",
                 i, a_out_valid, a_sum, a_carry, a_ovf, es[i], ec[i], eo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bx[4] = '{8'h01, 8'hFF, 8'h0F, 8'h55};
    logic [7:0] by[4] = '{8'h01, 8'h01, 8'hF1, 8'h55};
    logic       bs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es[4] = '{8'h02, 8'h00, 8'h00, 8'h00};
    logic       ec[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) drive8(1'b1, bx[i], by[i], bs[i], 1'b0);
      else       a_in_valid = 1'b0;
      #1;
      if (i >= 2) begin
        n_chk++;
        if (a_out_valid !== 1'b1 || a_sum !== es[i-2] || a_carry !== ec[i-2] || a_ovf !== 1'b0)
          $display("FAIL b2b%0d: got vld=%b sum=%h c=%b o=%b want 1 %h %b 0",
                   i - 2, a_out_valid, a_sum, a_carry, a_ovf, es[i-2], ec[i-2]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] sx[3] = '{8'h11, 8'h90, 8'h40};
    logic [7:0] sy[3] = '{8'h22, 8'h10, 8'h40};
    logic       ss[3] = '{1'b0, 1'b1, 1'b0};
    logic       st[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es[3] = '{8'h33, 8'h80, 8'h7F};
    logic       ec[3] = '{1'b0, 1'b1, 1'b0};
    logic       eo[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] got_s[$];
    logic       got_c[$];
    logic       got_o[$];
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive8(1'b1, sx[i], sy[i], ss[i], st[i]);
      if (i == 2) a_out_ready = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_chk++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_sum !== es[0] || a_carry !== ec[0])
        $display("FAIL stall_hold%0d: got rdy=%b vld=%b sum=%h c=%b want 0 1 %h %b",
                 i, a_in_ready, a_out_valid, a_sum, a_carry, es[0], ec[0]);
      else n_pass++;
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) a_in_valid = 1'b0;
      #1;
      if (a_out_valid && a_out_ready) begin
        got_s.push_back(a_sum); got_c.push_back(a_carry); got_o.push_back(a_ovf);
      end
    end
    n_chk++; if (got_s.size() != 3) $display("FAIL stall_count: got %0d results want 3", got_s.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got_s.size(); i++) begin
      n_chk++;
      if (got_s[i] !== es[i] || got_c[i] !== ec[i] || got_o[i] !== eo[i])
        $display("FAIL stall_order%0d: got sum=%h c=%b o=%b want %h %b %b",
                 i, got_s[i], got_c[i], got_o[i], es[i], ec[i], eo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight;
    int seen;
    a_out_ready = 1'b1;
    @(negedge clk); drive8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk); drive8(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_out_valid !== 1'b0 || a_sum !== 8'h00 || a_in_ready !== 1'b1)
      $display("FAIL rst_async: got vld=%b sum=%h rdy=%b want 0 00 1", a_out_valid, a_sum, a_in_ready);
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b1;
    drive8(1'b1, 8'h0A, 8'h0B, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) a_in_valid = 1'b0;
      #1;
      if (a_out_valid) begin
        seen++;
        n_chk++;
        if (i != 2 || a_sum !== 8'h15)
          $display("FAIL rst_flush: got sum=%h at cycle %0d want 15 at cycle 2", a_sum, i);
        else n_pass++;
      end
    end
    n_chk++; if (seen != 1) $display("FAIL rst_flush_count: got %0d results want 1", seen); else n_pass++;
  endtask

  task automatic test_random32;
    exp_t q[$];
    exp_t e;
    int   acc = 0;
    int   cyc = 0;
    int   stl = 0;
    int   limit = 60000;
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    while ((acc < 10000 || q.size() != 0) && cyc < limit) begin
      @(negedge clk);
      b_in_valid  = (acc < 10000) && ($urandom_range(0, 9) < 7);
      b_out_ready = ($urandom_range(0, 9) < 7) || (acc >= 10000);
      b_x   = $urandom;
      b_y   = $urandom;
      b_sub = 1'($urandom_range(0, 1));
      b_sat = 1'($urandom_range(0, 1));
      #1;
      if (b_out_valid && b_out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL rand_spurious: got result %h with nothing pending", b_sum);
        end else begin
          e = q.pop_front();
          if (b_sum !== e.s || b_carry !== e.c || b_ovf !== e.o)
            $display("FAIL rand_result: got sum=%h c=%b o=%b want %h %b %b", b_sum, b_carry, b_ovf, e.s, e.c, e.o);
          else n_pass++;
          if (stl == e.stl) begin
            n_chk++;
            if (cyc - e.cyc != 4) $display("FAIL rand_latency: got %0d want 4", cyc - e.cyc);
            else n_pass++;
          end
        end
      end
      if (b_in_valid && b_in_ready) begin
        e = model32(b_x, b_y, b_sub, b_sat);
        e.cyc = cyc;
        e.stl = stl;
        q.push_back(e);
        acc++;
      end
      if (b_out_valid && !b_out_ready) stl++;
      cyc++;
    end
    n_chk++;
    if (acc != 10000 || q.size() != 0)
      $display("FAIL rand_complete: got accepted=%0d pending=%0d want 10000 0", acc, q.size());
    else n_pass++;
    b_in_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random32();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
